detect_arbiter: RTL

DETECT_ARBITER -- requirements
Module: detect_arbiter

---
 rtl/detect_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/detect_arbiter.sv
// Round-robin arbiter time-sharing one "0 1 0* 1" sequence detector across
// NUM_CH serial channels, each with its own FSM context and saturating hit counter.
module detect_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         bit_in,
  output logic [NUM_CH-1:0]         grant,
  output logic                      z_valid,
  output logic [$clog2(NUM_CH)-1:0] z_ch,
  output logic                      z,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [CNT_W-1:0]          rd_count
);

  localparam int CH_W = $clog2(NUM_CH);
  // Counter ceiling is the two-digit display limit, clipped if CNT_W is too narrow.
  localparam int SAT = ((2 ** CNT_W) - 1 < 99) ? (2 ** CNT_W) - 1 : 99;
  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAW0   = 2'd1,
    SAW01  = 2'd2,
    SAW01Z = 2'd3
  } state_t;

  logic [CH_W-1:0]               ptr_q;
  logic [CH_W-1:0]               gnt_idx;
  logic                          gnt_any;
  logic [NUM_CH-1:0][1:0]        ctx_all;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_all;
  state_t                        cur_st;
  state_t                        nxt_st;
  logic                          cur_bit;
  logic                          det;
  logic                          z_valid_q;
  logic                          z_q;
  logic [CH_W-1:0]               z_ch_q;

  // Search from ptr upward with wrap; first requester found wins.
  always_comb begin
    int unsigned idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (rst && ena) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = CH_W'(idx);
        end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
    end
  end

  // Shared detector next-state logic operating on the granted channel's context.
  always_comb begin
    cur_st  = state_t'(ctx_all[gnt_idx]);
    cur_bit = bit_in[gnt_idx];
    nxt_st  = cur_st;
    det     = 1'b0;
    case (cur_st)
      IDLE:   nxt_st = cur_bit ? IDLE : SAW0;
      SAW0:   nxt_st = cur_bit ? SAW01 : SAW0;
      SAW01: begin
        if (cur_bit) begin
          nxt_st = IDLE;
          det    = 1'b1;
        end else begin
          nxt_st = SAW01Z;
        end
      end
      SAW01Z: begin
        if (cur_bit) begin
          nxt_st = SAW01;
          det    = 1'b1;
        end
      end
      default: nxt_st = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           ctx_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          ctx_q <= IDLE;
          cnt_q <= '0;
        end else if (grant[gi]) begin
          ctx_q <= nxt_st;
          if (det && (cnt_q != SAT_V)) cnt_q <= cnt_q + 1'b1;
        end
      end

      assign ctx_all[gi] = ctx_q;
      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      z_valid_q <= 1'b0;
      z_q       <= 1'b0;
      z_ch_q    <= '0;
    end else begin
      z_valid_q <= gnt_any;
      z_q       <= gnt_any & det;
      if (gnt_any) begin
        z_ch_q <= gnt_idx;
        ptr_q  <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign z_valid  = z_valid_q;
  assign z        = z_q;
  assign z_ch     = z_ch_q;
  assign rd_count = (int'(rd_ch) < NUM_CH) ? cnt_all[rd_ch] : '0;

endmodule
